// File: rtl/multicycle_sequencer_pkg.sv
// Shared types and constants for the multi-cycle sequencer (package seq_pkg).
// Holds the state enum, the opcode/ALU/select/branch encodings and the opcode class helpers.
package seq_pkg;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } stateT;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_AND   = 4'h3;
  localparam logic [3:0] OP_OR    = 4'h4;
  localparam logic [3:0] OP_XOR   = 4'h5;
  localparam logic [3:0] OP_NOT   = 4'h6;
  localparam logic [3:0] OP_SLT   = 4'h7;
  localparam logic [3:0] OP_LI    = 4'h8;
  localparam logic [3:0] OP_LUI   = 4'h9;
  localparam logic [3:0] OP_LOAD  = 4'hA;
  localparam logic [3:0] OP_STORE = 4'hB;
  localparam logic [3:0] OP_BEQ   = 4'hC;
  localparam logic [3:0] OP_BNE   = 4'hD;
  localparam logic [3:0] OP_JUMP  = 4'hE;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_NOT = 3'd5;
  localparam logic [2:0] ALU_SLT = 3'd6;

  localparam logic [1:0] SEL_ALU   = 2'b00;
  localparam logic [1:0] SEL_MEM   = 2'b01;
  localparam logic [1:0] SEL_SHIFT = 2'b10;

  localparam logic [3:0] BR_INC = 4'b0000;
  localparam logic [3:0] BR_EQ  = 4'b0001;
  localparam logic [3:0] BR_NE  = 4'b0010;
  localparam logic [3:0] BR_JMP = 4'b0100;

  typedef struct packed {
    logic       pcWrite;
    logic       regWrite;
    logic       dataMemoryFlag;
    logic       memRead;
    logic [3:0] branchUnitSignals;
    logic [2:0] aluOp;
    logic       shiftUnit;
    logic [1:0] mainSelect;
    logic       halted;
  } ctrlT;

  // ALU, LI and LUI finish through WRITEBACK without touching data memory.
  function automatic logic isRegOp(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_LUI);
  endfunction

  function automatic logic isMemOp(input logic [3:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Controller-to-datapath bundle; master = sequencer, slave = datapath.
// instrRetired exists only when PERF_COUNTERS_EN is defined.
interface multicycle_sequencer_if #(
  parameter int OPCODE_W = 4
`ifdef PERF_COUNTERS_EN
  , parameter int CNT_W  = 16
`endif
);
  logic [OPCODE_W-1:0] opcode;
  logic                memReady;
  logic                pcWrite;
  logic                regWrite;
  logic                dataMemoryFlag;
  logic                memRead;
  logic [3:0]          branchUnitSignals;
  logic [2:0]          ALUOp;
  logic                shiftUnit;
  logic [1:0]          mainSelect;
  logic                halted;
`ifdef PERF_COUNTERS_EN
  logic [CNT_W-1:0]    instrRetired;
`endif

  modport master (
    input  opcode, memReady,
    output pcWrite, regWrite, dataMemoryFlag, memRead, branchUnitSignals,
           ALUOp, shiftUnit, mainSelect, halted
`ifdef PERF_COUNTERS_EN
    , output instrRetired
`endif
  );

  modport slave (
    output opcode, memReady,
    input  pcWrite, regWrite, dataMemoryFlag, memRead, branchUnitSignals,
           ALUOp, shiftUnit, mainSelect, halted
`ifdef PERF_COUNTERS_EN
    , input instrRetired
`endif
  );
endinterface

// File: rtl/multicycle_sequencer_decode.sv
// Combinational map from (state, latched opcode) to the control bundle.
// memReady only qualifies the PC update of a STORE completing in MEM.
module seq_decode
  import seq_pkg::*;
(
  input  stateT      state,
  input  logic [3:0] latchedOpcode,
  input  logic       memReady,
  output ctrlT       ctrl
);

  ctrlT sel;

  // Instruction-level select values, held from EXECUTE to the last state.
  always_comb begin
    sel = '0;
    case (latchedOpcode)
      OP_ADD:   sel.aluOp = ALU_ADD;
      OP_SUB:   sel.aluOp = ALU_SUB;
      OP_AND:   sel.aluOp = ALU_AND;
      OP_OR:    sel.aluOp = ALU_OR;
      OP_XOR:   sel.aluOp = ALU_XOR;
      OP_NOT:   sel.aluOp = ALU_NOT;
      OP_SLT:   sel.aluOp = ALU_SLT;
      OP_LI: begin
        sel.mainSelect = SEL_SHIFT;
        sel.shiftUnit  = 1'b0;
      end
      OP_LUI: begin
        sel.mainSelect = SEL_SHIFT;
        sel.shiftUnit  = 1'b1;
      end
      OP_LOAD:  sel.mainSelect        = SEL_MEM;
      OP_BEQ:   sel.branchUnitSignals = BR_EQ;
      OP_BNE:   sel.branchUnitSignals = BR_NE;
      OP_JUMP:  sel.branchUnitSignals = BR_JMP;
      default:  sel = '0;
    endcase
  end

  // Per-state strobes layered on top of the held selects.
  always_comb begin
    ctrl = '0;
    case (state)
      S_EXECUTE: begin
        ctrl = sel;
        if (isRegOp(latchedOpcode) || isMemOp(latchedOpcode)) begin
          ctrl.pcWrite = 1'b0;
        end else begin
          ctrl.pcWrite = 1'b1;
        end
      end
      S_MEM: begin
        ctrl                = sel;
        ctrl.memRead        = (latchedOpcode == OP_LOAD);
        ctrl.dataMemoryFlag = (latchedOpcode == OP_STORE);
        // A STORE retires in the very cycle memory acknowledges it.
        ctrl.pcWrite        = (latchedOpcode == OP_STORE) && memReady;
      end
      S_WRITEBACK: begin
        ctrl          = sel;
        ctrl.regWrite = 1'b1;
        ctrl.pcWrite  = 1'b1;
      end
      S_HALT:  ctrl.halted = 1'b1;
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle FSM controller: FETCH/DECODE/EXECUTE/MEM/WRITEBACK plus absorbing HALT.
// Optional retired-instruction counter guarded by PERF_COUNTERS_EN.
module multicycle_sequencer
  import seq_pkg::*;
#(
  parameter int                  OPCODE_W    = 4,
  parameter logic [OPCODE_W-1:0] HALT_OPCODE = OP_HALT
`ifdef PERF_COUNTERS_EN
  , parameter int                CNT_W       = 16
`endif
)(
  input logic                  clk,
  input logic                  reset,
  multicycle_sequencer_if.master bus
);

  stateT               state;
  stateT               nextState;
  logic [OPCODE_W-1:0] latchedOpcode;
  ctrlT                ctrl;

  // State register and opcode capture at the DECODE edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_FETCH;
      latchedOpcode <= '0;
    end else begin
      state <= nextState;
      if (state == S_DECODE) begin
        latchedOpcode <= bus.opcode;
      end else begin
        latchedOpcode <= latchedOpcode;
      end
    end
  end

  // Transition logic; EXECUTE and MEM branch on the latched opcode class.
  always_comb begin
    nextState = state;
    case (state)
      S_FETCH: nextState = S_DECODE;
      S_DECODE: begin
        if (bus.opcode == HALT_OPCODE) begin
          nextState = S_HALT;
        end else begin
          nextState = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        if (isRegOp(latchedOpcode)) begin
          nextState = S_WRITEBACK;
        end else if (isMemOp(latchedOpcode)) begin
          nextState = S_MEM;
        end else begin
          nextState = S_FETCH;
        end
      end
      S_MEM: begin
        if (!bus.memReady) begin
          nextState = S_MEM;
        end else if (latchedOpcode == OP_LOAD) begin
          nextState = S_WRITEBACK;
        end else begin
          nextState = S_FETCH;
        end
      end
      S_WRITEBACK: nextState = S_FETCH;
      S_HALT:      nextState = S_HALT;
      default:     nextState = S_FETCH;
    endcase
  end

  seq_decode uDecode (
    .state         (state),
    .latchedOpcode (latchedOpcode),
    .memReady      (bus.memReady),
    .ctrl          (ctrl)
  );

  assign bus.pcWrite           = ctrl.pcWrite;
  assign bus.regWrite          = ctrl.regWrite;
  assign bus.dataMemoryFlag    = ctrl.dataMemoryFlag;
  assign bus.memRead           = ctrl.memRead;
  assign bus.branchUnitSignals = ctrl.branchUnitSignals;
  assign bus.ALUOp             = ctrl.aluOp;
  assign bus.shiftUnit         = ctrl.shiftUnit;
  assign bus.mainSelect        = ctrl.mainSelect;
  assign bus.halted            = ctrl.halted;

`ifdef PERF_COUNTERS_EN
  logic [CNT_W-1:0] retiredCount;

  // One count per PC update; wraps naturally and holds in HALT.
  always_ff @(posedge clk) begin
    if (reset) begin
      retiredCount <= '0;
    end else if (ctrl.pcWrite) begin
      retiredCount <= retiredCount + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      retiredCount <= retiredCount;
    end
  end

  assign bus.instrRetired = retiredCount;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed, table-driven bench for multicycle_sequencer; each record is one clock cycle.
// Covers the counter checks when PERF_COUNTERS_EN is defined.
module tb_multicycle_sequencer;
  import seq_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  typedef struct {
    logic        rst;
    logic [3:0]  op;
    logic        rdy;
    logic [14:0] exp;
  } vecT;

  vecT vecs[$];

`ifdef PERF_COUNTERS_EN
  multicycle_sequencer_if #(.OPCODE_W(4), .CNT_W(4)) bus ();
  multicycle_sequencer #(.OPCODE_W(4), .HALT_OPCODE(4'hF), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .bus(bus));
`else
  multicycle_sequencer_if #(.OPCODE_W(4)) bus ();
  multicycle_sequencer #(.OPCODE_W(4), .HALT_OPCODE(4'hF)) dut (
    .clk(clk), .reset(reset), .bus(bus));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs packed as {pc, rw, dmf, mr, br[3:0], alu[2:0], sh, sel[1:0], halted}.
  function automatic logic [14:0] mk(input logic pc, input logic rw, input logic dmf,
                                     input logic mr, input logic [3:0] br, input logic [2:0] alu,
                                     input logic sh, input logic [1:0] sel, input logic h);
    return {pc, rw, dmf, mr, br, alu, sh, sel, h};
  endfunction

  function automatic logic [14:0] actual();
    return {bus.pcWrite, bus.regWrite, bus.dataMemoryFlag, bus.memRead, bus.branchUnitSignals,
            bus.ALUOp, bus.shiftUnit, bus.mainSelect, bus.halted};
  endfunction

  task automatic add(input logic r, input logic [3:0] op, input logic rdy, input logic [14:0] e);
    vecT v;
    v.rst = r; v.op = op; v.rdy = rdy; v.exp = e;
    vecs.push_back(v);
  endtask

  // Drive one cycle's inputs, compare mid-cycle, then advance past the edge.
  task automatic cycleCheck(input logic r, input logic [3:0] op, input logic rdy,
                            input logic [14:0] e, input string name, input int idx);
    reset = r; bus.opcode = op; bus.memReady = rdy;
    #2;
    checks++;
    if (actual() !== e) begin
      errors++;
      $display("FAIL %s[%0d]: got %b, expected %b", name, idx, actual(), e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic r, input logic [3:0] op, input logic rdy);
    reset = r; bus.opcode = op; bus.memReady = rdy;
    @(posedge clk);
    #1;
  endtask

  localparam logic [14:0] Z = 15'd0;

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1; bus.opcode = 4'h0; bus.memReady = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // ADD: ALUOp 000, select 00, pc+rw only in cycle 4
    add(1'b0, OP_ADD, 1'b1, Z);
    add(1'b0, OP_ADD, 1'b1, Z);
    add(1'b0, OP_ADD, 1'b1, Z);
    add(1'b0, OP_ADD, 1'b1, mk(1'b1,1'b1,1'b0,1'b0,4'b0000,3'b000,1'b0,2'b00,1'b0));
    // SUB and SLT show the ALUOp mapping
    add(1'b0, OP_SUB, 1'b1, Z);
    add(1'b0, OP_SUB, 1'b1, Z);
    add(1'b0, OP_SUB, 1'b1, mk(1'b0,1'b0,1'b0,1'b0,4'b0000,3'b001,1'b0,2'b00,1'b0));
    add(1'b0, OP_SUB, 1'b1, mk(1'b1,1'b1,1'b0,1'b0,4'b0000,3'b001,1'b0,2'b00,1'b0));
    add(1'b0, OP_SLT, 1'b0, Z);
    add(1'b0, OP_SLT, 1'b0, Z);
    add(1'b0, OP_SLT, 1'b0, mk(1'b0,1'b0,1'b0,1'b0,4'b0000,3'b110,1'b0,2'b00,1'b0));
    add(1'b0, OP_SLT, 1'b0, mk(1'b1,1'b1,1'b0,1'b0,4'b0000,3'b110,1'b0,2'b00,1'b0));
    // LI and LUI route the shift unit
    add(1'b0, OP_LI, 1'b0, Z);
    add(1'b0, OP_LI, 1'b0, Z);
    add(1'b0, OP_LI, 1'b0, mk(1'b0,1'b0,1'b0,1'b0,4'b0000,3'b000,1'b0,2'b10,1'b0));
    add(1'b0, OP_LI, 1'b0, mk(1'b1,1'b1,1'b0,1'b0,4'b0000,3'b000,1'b0,2'b10,1'b0));
    add(1'b0, OP_LUI, 1'b0, Z);
    add(1'b0, OP_LUI, 1'b0, Z);
    add(1'b0, OP_LUI, 1'b0, mk(1'b0,1'b0,1'b0,1'b0,4'b0000,3'b000,1'b1,2'b10,1'b0));
    add(1'b0, OP_LUI, 1'b0, mk(1'b1,1'b1,1'b0,1'b0,4'b0000,3'b000,1'b1,2'b10,1'b0));
    // LOAD with three wait cycles: 8 cycles total, memReady ignored in EXECUTE/WRITEBACK
    add(1'b0, OP_LOAD, 1'b1, Z);
    add(1'b0, OP_LOAD, 1'b1, Z);
    add(1'b0, OP_LOAD, 1'b1, mk(1'b0,1'b0,1'b0,1'b0,4'b0000,3'b000,1'b0,2'b01,1'b0));
    for (int i = 0; i < 3; i++)
      add(1'b0, OP_LOAD, 1'b0, mk(1'b0,1'b0,1'b0,1'b1,4'b0000,3'b000,1'b0,2'b01,1'b0));
    add(1'b0, OP_LOAD, 1'b1, mk(1'b0,1'b0,1'b0,1'b1,4'b0000,3'b000,1'b0,2'b01,1'b0));
    add(1'b0, OP_LOAD, 1'b1, mk(1'b1,1'b1,1'b0,1'b0,4'b0000,3'b000,1'b0,2'b01,1'b0));
    // STORE with immediate ready: single-cycle strobe, no regWrite
    add(1'b0, OP_STORE, 1'b1, Z);
    add(1'b0, OP_STORE, 1'b1, Z);
    add(1'b0, OP_STORE, 1'b1, Z);
    add(1'b0, OP_STORE, 1'b1, mk(1'b1,1'b0,1'b1,1'b0,4'b0000,3'b000,1'b0,2'b00,1'b0));
    // Branches and NOP retire from EXECUTE
    add(1'b0, OP_BNE, 1'b1, Z);
    add(1'b0, OP_BNE, 1'b1, Z);
    add(1'b0, OP_BNE, 1'b1, mk(1'b1,1'b0,1'b0,1'b0,4'b0010,3'b000,1'b0,2'b00,1'b0));
    add(1'b0, OP_BEQ, 1'b0, Z);
    add(1'b0, OP_BEQ, 1'b0, Z);
    add(1'b0, OP_BEQ, 1'b0, mk(1'b1,1'b0,1'b0,1'b0,4'b0001,3'b000,1'b0,2'b00,1'b0));
    add(1'b0, OP_JUMP, 1'b0, Z);
    add(1'b0, OP_JUMP, 1'b0, Z);
    add(1'b0, OP_JUMP, 1'b0, mk(1'b1,1'b0,1'b0,1'b0,4'b0100,3'b000,1'b0,2'b00,1'b0));
    add(1'b0, OP_NOP, 1'b1, Z);
    add(1'b0, OP_NOP, 1'b1, Z);
    add(1'b0, OP_NOP, 1'b1, mk(1'b1,1'b0,1'b0,1'b0,4'b0000,3'b000,1'b0,2'b00,1'b0));
    // Reset in the second stalled MEM cycle of a STORE
    add(1'b0, OP_STORE, 1'b0, Z);
    add(1'b0, OP_STORE, 1'b0, Z);
    add(1'b0, OP_STORE, 1'b0, Z);
    add(1'b0, OP_STORE, 1'b0, mk(1'b0,1'b0,1'b1,1'b0,4'b0000,3'b000,1'b0,2'b00,1'b0));
    add(1'b1, OP_STORE, 1'b0, mk(1'b0,1'b0,1'b1,1'b0,4'b0000,3'b000,1'b0,2'b00,1'b0));
    add(1'b0, OP_NOP, 1'b0, Z);
    add(1'b0, OP_NOP, 1'b0, Z);
    add(1'b0, OP_NOP, 1'b0, mk(1'b1,1'b0,1'b0,1'b0,4'b0000,3'b000,1'b0,2'b00,1'b0));

    for (int i = 0; i < vecs.size(); i++)
      cycleCheck(vecs[i].rst, vecs[i].op, vecs[i].rdy, vecs[i].exp, "vec", i);

    // HALT parks the FSM; memReady toggling must not matter
    cycleCheck(1'b0, OP_HALT, 1'b0, Z, "haltFetch", 0);
    cycleCheck(1'b0, OP_HALT, 1'b0, Z, "haltDecode", 0);
    for (int i = 0; i < 20; i++)
      cycleCheck(1'b0, OP_ADD, i[0], mk(1'b0,1'b0,1'b0,1'b0,4'b0000,3'b000,1'b0,2'b00,1'b1),
                 "haltHold", i);
    cycleCheck(1'b1, OP_ADD, 1'b0, mk(1'b0,1'b0,1'b0,1'b0,4'b0000,3'b000,1'b0,2'b00,1'b1),
               "haltReset", 0);
    cycleCheck(1'b0, OP_ADD, 1'b1, Z, "postHaltAdd", 1);
    cycleCheck(1'b0, OP_ADD, 1'b1, Z, "postHaltAdd", 2);
    cycleCheck(1'b0, OP_ADD, 1'b1, Z, "postHaltAdd", 3);
    cycleCheck(1'b0, OP_ADD, 1'b1, mk(1'b1,1'b1,1'b0,1'b0,4'b0000,3'b000,1'b0,2'b00,1'b0),
               "postHaltAdd", 4);

`ifdef PERF_COUNTERS_EN
    step(1'b1, OP_NOP, 1'b0);
    checks++;
    if (bus.instrRetired !== 4'd0) begin
      errors++;
      $display("FAIL cntReset: got %0d, expected 0", bus.instrRetired);
    end
    for (int n = 0; n < 17; n++) begin
      for (int c = 0; c < 3; c++) step(1'b0, OP_NOP, 1'b0);
      if (n == 14) begin
        checks++;
        if (bus.instrRetired !== 4'd15) begin
          errors++;
          $display("FAIL cnt15: got %0d, expected 15", bus.instrRetired);
        end
      end
    end
    checks++;
    if (bus.instrRetired !== 4'd1) begin
      errors++;
      $display("FAIL cntWrap: got %0d, expected 1", bus.instrRetired);
    end
    for (int c = 0; c < 6; c++) step(1'b0, OP_HALT, 1'b1);
    checks++;
    if (bus.instrRetired !== 4'd1 || bus.halted !== 1'b1) begin
      errors++;
      $display("FAIL cntHalt: got cnt=%0d halted=%b, expected cnt=1 halted=1",
               bus.instrRetired, bus.halted);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
